// File: rtl/t03_mmio_requester.sv
`timescale 1ns/1ps
// Bus initiator between the core and the t03 MMIO responder: arbitrates fetch/load/store,
// holds the strobe until ack (or timeout) and returns data with a one-cycle done pulse.
module t03_mmio_requester #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_fetch_req,
   input  logic [31:0] i_fetch_addr,
   output logic [31:0] i_instr,
   output logic        i_fetch_done,
   input  logic        d_read_req,
   input  logic        d_write_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        freeze,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_dataOut,
   input  logic        mem_ack,
   output logic        timeout_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;
   typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

   state_t      state;
   kind_t       kind;
   logic [31:0] count;
   logic        any_req;
   logic        timed_out;
   logic [31:0] rd_value;

   assign any_req   = i_fetch_req | d_read_req | d_write_req;
   assign timed_out = (TIMEOUT_CYCLES != 0) && (count + 32'd1 == TIMEOUT_CYCLES);
   // An ack on the final allowed cycle still wins over the timeout.
   assign rd_value  = mem_ack ? mem_dataOut : 32'hDEADDEAD;

   // NOTE: freeze is combinational on the request inputs so the core stalls in the same
   // cycle it asks, without waiting for the request to be registered.
   assign freeze = (state == ST_BUS) || ((state == ST_IDLE) && any_req);

   // NOTE: all state and registered outputs use non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         kind         <= K_FETCH;
         count        <= '0;
         i_instr      <= '0;
         i_fetch_done <= 1'b0;
         d_rdata      <= '0;
         d_done       <= 1'b0;
         mem_address  <= '0;
         mem_data     <= '0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         i_fetch_done <= 1'b0;
         d_done       <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state    <= ST_BUS;
                  count    <= '0;
                  mem_data <= d_wdata;
                  if (d_write_req) begin
                     kind        <= K_WRITE;
                     mem_write   <= 1'b1;
                     mem_address <= {d_addr[31:2], 2'b00};
                  end else if (d_read_req) begin
                     kind        <= K_READ;
                     mem_read    <= 1'b1;
                     mem_address <= {d_addr[31:2], 2'b00};
                  end else begin
                     kind        <= K_FETCH;
                     mem_read    <= 1'b1;
                     mem_address <= {i_fetch_addr[31:2], 2'b00};
                  end
               end
            end
            ST_BUS: begin
               if (mem_ack || timed_out) begin
                  state     <= ST_DONE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (!mem_ack) timeout_err <= 1'b1;
                  unique case (kind)
                     K_FETCH: begin
                        i_instr      <= rd_value;
                        i_fetch_done <= 1'b1;
                     end
                     K_READ: begin
                        d_rdata <= rd_value;
                        d_done  <= 1'b1;
                     end
                     default: d_done <= 1'b1;
                  endcase
               end else begin
                  count <= count + 32'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_t03_mmio_requester.sv
`timescale 1ns/1ps
// Self-checking bench for t03_mmio_requester: a transaction-timeline model predicts every
// output each cycle, with a small MMIO responder model (configurable ack latency).
module tb_t03_mmio_requester;

   localparam int TO = 4;
   localparam int KF = 0;
   localparam int KR = 1;
   localparam int KW = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0, read_req = 1'b0, write_req = 1'b0;
   logic [31:0] fetch_addr = '0, d_addr = '0, d_wdata = '0;
   logic [31:0] i_instr, d_rdata, mem_address, mem_data, mem_dataOut;
   logic        i_fetch_done, d_done, freeze, mem_read, mem_write, mem_ack, timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   // responder model
   logic [31:0] rsp_mem [0:15];
   int          rsp_cnt    = 0;
   int          resp_lat   = 0;
   logic        resp_noack = 1'b0;
   logic        stray_ack  = 1'b0;

   // expected-value model
   logic [31:0] ref_mem [0:15];
   logic        exp_read = 0, exp_write = 0, exp_fdone = 0, exp_ddone = 0, exp_freeze = 0, exp_terr = 0;
   logic [31:0] exp_addr = '0, exp_mdata = '0, exp_instr = '0, exp_rdata = '0;
   logic        chk_en = 1'b0;
   logic [31:0] last_bus_addr = '0;

   t03_mmio_requester #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr), .i_instr(i_instr), .i_fetch_done(i_fetch_done),
      .d_read_req(read_req), .d_write_req(write_req), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .freeze(freeze),
      .mem_address(mem_address), .mem_data(mem_data), .mem_read(mem_read), .mem_write(mem_write),
      .mem_dataOut(mem_dataOut), .mem_ack(mem_ack), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   assign mem_ack = ((mem_read || mem_write) && !resp_noack && (rsp_cnt == resp_lat)) || stray_ack;
   assign mem_dataOut = rsp_mem[mem_address[5:2]];

   always @(posedge clk) begin
      if (mem_read || mem_write) rsp_cnt <= rsp_cnt + 1;
      else                       rsp_cnt <= 0;
      if (mem_ack && mem_write) rsp_mem[mem_address[5:2]] <= mem_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_read",     32'(mem_read),     32'(exp_read));
         check("mem_write",    32'(mem_write),    32'(exp_write));
         check("i_fetch_done", 32'(i_fetch_done), 32'(exp_fdone));
         check("d_done",       32'(d_done),       32'(exp_ddone));
         check("freeze",       32'(freeze),       32'(exp_freeze));
         check("timeout_err",  32'(timeout_err),  32'(exp_terr));
         check("i_instr",      i_instr,           exp_instr);
         check("d_rdata",      d_rdata,           exp_rdata);
         if (exp_read || exp_write) check("mem_address", mem_address, exp_addr);
         if (exp_write)             check("mem_data",    mem_data,    exp_mdata);
         if (mem_read || mem_write) last_bus_addr = mem_address;
      end
   end

   // Requests are already driven in an IDLE cycle; walks the transaction's timeline:
   // capture edge, k strobe cycles (k = lat+1, or TO on no ack), one DONE cycle, back to IDLE.
   task automatic serve(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic noack);
      int          k;
      logic [31:0] rd;
      logic [3:0]  w;
      k          = noack ? TO : lat + 1;
      w          = addr[5:2];
      resp_lat   = lat;
      resp_noack = noack;
      exp_freeze = 1'b1;
      @(posedge clk); #1;
      exp_read  = (kind != KW);
      exp_write = (kind == KW);
      exp_addr  = {addr[31:2], 2'b00};
      exp_mdata = wdata;
      repeat (k - 1) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      exp_read   = 1'b0;
      exp_write  = 1'b0;
      exp_freeze = 1'b0;
      rd = noack ? 32'hDEADDEAD : ref_mem[w];
      case (kind)
         KF: begin exp_fdone = 1'b1; exp_instr = rd; end
         KR: begin exp_ddone = 1'b1; exp_rdata = rd; end
         default: begin exp_ddone = 1'b1; if (!noack) ref_mem[w] = wdata; end
      endcase
      if (noack) exp_terr = 1'b1;
      @(posedge clk); #1;
      exp_fdone = 1'b0;
      exp_ddone = 1'b0;
      case (kind)
         KF: fetch_req = 1'b0;
         KR: read_req  = 1'b0;
         default: begin write_req = 1'b0; read_req = 1'b0; end
      endcase
      exp_freeze = fetch_req | read_req | write_req;
      resp_noack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin rsp_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
      rsp_mem[0] = 32'h003100B3; rsp_mem[1] = 32'h403100B3; rsp_mem[2] = 32'h3E810093;
      ref_mem[0] = 32'h003100B3; ref_mem[1] = 32'h403100B3; ref_mem[2] = 32'h3E810093;

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("reset mem_address", mem_address, 32'h0);
      check("reset mem_data",    mem_data,    32'h0);
      rst = 1'b0;

      // fetches at rising ack latencies, first one at the 3-cycle minimum
      fetch_req = 1'b1; fetch_addr = 32'h0; serve(KF, 32'h0, 32'h0, 0, 1'b0);
      check("fetch0 instr", i_instr, 32'h003100B3);
      fetch_req = 1'b1; fetch_addr = 32'h4; serve(KF, 32'h4, 32'h0, 1, 1'b0);
      check("fetch4 instr", i_instr, 32'h403100B3);
      fetch_req = 1'b1; fetch_addr = 32'h8; serve(KF, 32'h8, 32'h0, 2, 1'b0);
      check("fetch8 instr", i_instr, 32'h3E810093);

      // store then load
      write_req = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF; serve(KW, 32'h8, 32'hDEADBEEF, 1, 1'b0);
      check("store keeps rdata", d_rdata, 32'h0);
      read_req = 1'b1; d_addr = 32'h8; serve(KR, 32'h8, 32'h0, 0, 1'b0);
      check("load8 rdata", d_rdata, 32'hDEADBEEF);

      // simultaneous load and fetch: load first, fetch waits
      fetch_req = 1'b1; fetch_addr = 32'h0; read_req = 1'b1; d_addr = 32'h4;
      serve(KR, 32'h4, 32'h0, 1, 1'b0);
      check("simul load rdata", d_rdata, 32'h403100B3);
      serve(KF, 32'h0, 32'h0, 0, 1'b0);
      check("simul fetch instr", i_instr, 32'h003100B3);

      // write and read together: write only
      write_req = 1'b1; read_req = 1'b1; d_addr = 32'hC; d_wdata = 32'h12345678;
      serve(KW, 32'hC, 32'h12345678, 2, 1'b0);
      check("w+r keeps rdata", d_rdata, 32'h403100B3);
      read_req = 1'b1; d_addr = 32'hC; serve(KR, 32'hC, 32'h0, 2, 1'b0);
      check("loadC rdata", d_rdata, 32'h12345678);

      // misaligned load
      read_req = 1'b1; d_addr = 32'h0000000B; serve(KR, 32'h0000000B, 32'h0, 0, 1'b0);
      check("misaligned address", last_bus_addr, 32'h00000008);
      check("misaligned rdata", d_rdata, 32'hDEADBEEF);

      // ack on the last cycle before the timeout limit
      read_req = 1'b1; d_addr = 32'h4; serve(KR, 32'h4, 32'h0, TO - 1, 1'b0);
      check("late ack rdata", d_rdata, 32'h403100B3);
      check("late ack no timeout", 32'(timeout_err), 32'h0);

      // timeout
      read_req = 1'b1; d_addr = 32'h0; serve(KR, 32'h0, 32'h0, 0, 1'b1);
      check("timeout rdata", d_rdata, 32'hDEADDEAD);
      check("timeout_err set", 32'(timeout_err), 32'h1);
      fetch_req = 1'b1; fetch_addr = 32'h8; serve(KF, 32'h8, 32'h0, 0, 1'b0);
      check("timeout_err sticky", 32'(timeout_err), 32'h1);

      // reset in the middle of a bus transaction, then stray acks
      fetch_req = 1'b1; fetch_addr = 32'h4; resp_lat = 3; exp_freeze = 1'b1;
      @(posedge clk); #1;
      exp_read = 1'b1; exp_addr = 32'h4;
      check("mem_read before reset", 32'(mem_read), 32'h1);
      rst = 1'b1; fetch_req = 1'b0;
      @(posedge clk); #1;
      exp_read = 1'b0; exp_write = 1'b0; exp_freeze = 1'b0; exp_fdone = 1'b0; exp_ddone = 1'b0;
      exp_instr = '0; exp_rdata = '0; exp_terr = 1'b0;
      rst = 1'b0; stray_ack = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      stray_ack = 1'b0;
      check("post-reset instr", i_instr, 32'h0);
      check("post-reset address", mem_address, 32'h0);
      repeat (2) begin @(posedge clk); #1; end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
